// File: rtl/cache_pmem_arbiter.sv
// cache_pmem_arbiter
//   Shares one physical-memory (cacheline adaptor) port between the
//   read-only instruction cache and the read/write-back data cache.
//   A request sampled in IDLE is granted and latched; the latched op,
//   address and write data are presented to memory until pmem_resp.
//   After each transaction there is one COOLDOWN cycle with commands low,
//   which gives the finished requester time to drop its request.
//   The D side has priority, except that a pending I request wins
//   whenever the previous grant went to D. This means I is bypassed by
//   at most one D transaction.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   i_pmem_read/address          I-cache line-fill request
//   i_pmem_rdata/resp            I-cache line data / completion pulse
//   d_pmem_read/write/address    D-cache fill or write-back request
//   d_pmem_wdata                 D-cache write-back line
//   d_pmem_rdata/resp            D-cache line data / completion pulse
//   pmem_read/write/address      memory command (from latched request)
//   pmem_wdata                   memory write data (0 unless D write)
//   pmem_rdata/resp              memory read data / completion pulse
module cache_pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, COOLDOWN} state_e;

  state_e              state_q, state_d;
  logic                last_was_d_q, last_was_d_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;

  logic d_req, grant_d, serving;

  assign d_req   = d_pmem_read | d_pmem_write;
  // D wins unless I is also waiting and D had the previous grant.
  assign grant_d = d_req & ~(i_pmem_read & last_was_d_q);

  always_comb begin
    state_d      = state_q;
    last_was_d_d = last_was_d_q;
    op_wr_d      = op_wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d      = SERVE_D;
          // read+write together is treated as a write-back
          op_wr_d      = d_pmem_write;
          addr_d       = d_pmem_address;
          wdata_d      = d_pmem_write ? d_pmem_wdata : '0;
          last_was_d_d = 1'b1;
        end else if (i_pmem_read) begin
          state_d      = SERVE_I;
          op_wr_d      = 1'b0;
          addr_d       = i_pmem_address;
          wdata_d      = '0;
          last_was_d_d = 1'b0;
        end
      end
      SERVE_I, SERVE_D: if (pmem_resp) state_d = COOLDOWN;
      COOLDOWN:         state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_was_d_q <= 1'b0;
      op_wr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_was_d_q <= last_was_d_d;
      op_wr_q      <= op_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Memory side sees only latched values, and only while serving.
  assign serving      = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign pmem_read    = serving & ~op_wr_q;
  assign pmem_write   = serving &  op_wr_q;
  assign pmem_address = serving ? addr_q  : '0;
  assign pmem_wdata   = serving ? wdata_q : '0;

  assign i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
module tb_cache_pmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic i_pmem_read, i_pmem_resp;
  logic [31:0] i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic d_pmem_read, d_pmem_write, d_pmem_resp;
  logic [31:0] d_pmem_address;
  logic [255:0] d_pmem_wdata, d_pmem_rdata;
  logic pmem_read, pmem_write, pmem_resp;
  logic [31:0] pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cache_pmem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    i_pmem_read = 0; i_pmem_address = '0;
    d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0;
  endtask

  task automatic do_reset();
    nxt(); clear_inputs(); rst = 1;
    nxt(); rst = 0;
  endtask

  // Memory responder. Called at #1 after a falling edge once the requests
  // are applied. It waits for a command and records what the command looked
  // like and whether it stayed constant. It then pulses pmem_resp after dly
  // quiet cycles. If scr_side is 0 or 1, it scrambles that requester's
  // address and data while the request is being served.
  task automatic serve(input int dly, input logic [255:0] rd, input int scr_side,
                       output int wcyc, output logic wr, output logic [31:0] a,
                       output logic [255:0] wd, output logic ir, output logic dr,
                       output logic stable, output logic bcast);
    wcyc = 0;
    while (!(pmem_read || pmem_write) && wcyc < 20) begin
      nxt(); #1; wcyc++;
    end
    if (!(pmem_read || pmem_write)) wcyc = -1;
    wr = pmem_write; a = pmem_address; wd = pmem_wdata;
    stable = pmem_read ^ pmem_write;
    for (int k = 0; k < dly; k++) begin
      nxt();
      if (scr_side == 1) begin d_pmem_address = $urandom; d_pmem_wdata = {8{$urandom}}; end
      if (scr_side == 0) i_pmem_address = $urandom;
      #1;
      if (pmem_write !== wr || pmem_read !== !wr || pmem_address !== a ||
          pmem_wdata !== wd || i_pmem_resp !== 0 || d_pmem_resp !== 0) stable = 0;
    end
    nxt(); pmem_resp = 1; pmem_rdata = rd; #1;
    ir = i_pmem_resp; dr = d_pmem_resp;
    bcast = (i_pmem_rdata === rd) && (d_pmem_rdata === rd);
  endtask

  task automatic test_reset();
    clear_inputs(); rst = 1; #1;
    nxt(); #1;
    vectors++; if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin miscompares++; $display("FAIL reset_ctrl got %b exp 0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}); end
    vectors++; if (pmem_address !== 32'h0 || pmem_wdata !== '0) begin miscompares++; $display("FAIL reset_data addr=%h exp 0", pmem_address); end
    nxt(); rst = 0;
  endtask

  task automatic test_lone_i();
    int w; logic wr, ir, dr, st, bc; logic [31:0] a; logic [255:0] wd, rd;
    rd = {32{8'hA5}};
    nxt(); i_pmem_read = 1; i_pmem_address = 32'h0000_1040; #1;
    serve(4, rd, -1, w, wr, a, wd, ir, dr, st, bc);
    vectors++; if (w !== 1) begin miscompares++; $display("FAIL lone_i_latency got %0d exp 1", w); end
    vectors++; if (wr !== 0 || a !== 32'h0000_1040) begin miscompares++; $display("FAIL lone_i_cmd wr=%b addr=%h exp 0 00001040", wr, a); end
    vectors++; if (ir !== 1 || dr !== 0 || !bc || !st) begin miscompares++; $display("FAIL lone_i_resp ir=%b dr=%b bc=%b st=%b exp 1 0 1 1", ir, dr, bc, st); end
    nxt(); pmem_resp = 0; i_pmem_read = 0; #1;
    vectors++; if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin miscompares++; $display("FAIL lone_i_cool got %b exp 0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}); end
  endtask

  task automatic test_lone_d_write();
    int w; logic wr, ir, dr, st, bc; logic [31:0] a; logic [255:0] wd, wdat;
    wdat = {16{16'h1234}};
    nxt(); nxt(); d_pmem_write = 1; d_pmem_address = 32'h0000_2000; d_pmem_wdata = wdat; #1;
    serve(3, '0, -1, w, wr, a, wd, ir, dr, st, bc);
    vectors++; if (w !== 1 || wr !== 1 || a !== 32'h0000_2000 || wd !== wdat) begin miscompares++; $display("FAIL lone_d_cmd w=%0d wr=%b addr=%h exp 1 1 00002000", w, wr, a); end
    vectors++; if (dr !== 1 || ir !== 0 || !st) begin miscompares++; $display("FAIL lone_d_resp dr=%b ir=%b st=%b exp 1 0 1", dr, ir, st); end
    nxt(); pmem_resp = 0; d_pmem_write = 0; #1;
    vectors++; if ({pmem_read, pmem_write, d_pmem_resp} !== 3'b0) begin miscompares++; $display("FAIL lone_d_cool got %b exp 000", {pmem_read, pmem_write, d_pmem_resp}); end
  endtask

  task automatic test_simultaneous();
    int w; logic wr, ir, dr, st, bc; logic [31:0] a; logic [255:0] wd;
    do_reset();
    i_pmem_read = 1; i_pmem_address = 32'h100; d_pmem_read = 1; d_pmem_address = 32'h200; #1;
    serve(2, {8{$urandom}}, -1, w, wr, a, wd, ir, dr, st, bc);
    vectors++; if (a !== 32'h200 || dr !== 1 || ir !== 0) begin miscompares++; $display("FAIL simul_first addr=%h dr=%b exp 00000200 1", a, dr); end
    nxt(); pmem_resp = 0; d_pmem_read = 0; #1;
    serve(2, {8{$urandom}}, -1, w, wr, a, wd, ir, dr, st, bc);
    vectors++; if (w !== 2 || a !== 32'h100 || ir !== 1 || dr !== 0) begin miscompares++; $display("FAIL simul_second w=%0d addr=%h ir=%b exp 2 00000100 1", w, a, ir); end
    nxt(); pmem_resp = 0; i_pmem_read = 0; #1;
  endtask

  task automatic test_anti_starvation();
    int w; logic wr, ir, dr, st, bc; logic [31:0] a; logic [255:0] wd;
    do_reset();
    i_pmem_read = 1; i_pmem_address = 32'h1111_0000; d_pmem_read = 1; d_pmem_address = 32'hD000_0000; #1;
    serve(1, '0, -1, w, wr, a, wd, ir, dr, st, bc);
    vectors++; if (a !== 32'hD000_0000 || dr !== 1) begin miscompares++; $display("FAIL starve_g0 addr=%h exp d0000000", a); end
    nxt(); pmem_resp = 0; d_pmem_address = 32'hD000_0040; #1;  // D re-requests at once
    serve(1, '0, -1, w, wr, a, wd, ir, dr, st, bc);
    vectors++; if (a !== 32'h1111_0000 || ir !== 1 || dr !== 0) begin miscompares++; $display("FAIL starve_g1 addr=%h ir=%b exp 11110000 1", a, ir); end
    nxt(); pmem_resp = 0; i_pmem_address = 32'h1111_0020; #1;
    serve(1, '0, -1, w, wr, a, wd, ir, dr, st, bc);
    vectors++; if (a !== 32'hD000_0040 || dr !== 1) begin miscompares++; $display("FAIL starve_g2 addr=%h exp d0000040", a); end
    nxt(); pmem_resp = 0; clear_inputs(); #1;
  endtask

  task automatic test_input_stability();
    int w; logic wr, ir, dr, st, bc; logic [31:0] a; logic [255:0] wd, wdat;
    wdat = {8{$urandom}};
    nxt(); d_pmem_write = 1; d_pmem_address = 32'h300; d_pmem_wdata = wdat; #1;
    serve(4, '0, 1, w, wr, a, wd, ir, dr, st, bc);
    vectors++; if (a !== 32'h300 || wd !== wdat || !st || dr !== 1) begin miscompares++; $display("FAIL stability addr=%h st=%b dr=%b exp 00000300 1 1", a, st, dr); end
    nxt(); pmem_resp = 0; clear_inputs(); #1;
  endtask

  task automatic test_reset_mid();
    int w; logic wr, ir, dr, st, bc; logic [31:0] a; logic [255:0] wd;
    do_reset();
    i_pmem_read = 1; i_pmem_address = 32'h5000; #1;
    nxt(); #1;
    vectors++; if (pmem_read !== 1) begin miscompares++; $display("FAIL rmid_cmd read=%b exp 1", pmem_read); end
    nxt(); nxt(); #2; rst = 1; pmem_resp = 1; #1;
    vectors++; if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0 || pmem_address !== 0) begin miscompares++; $display("FAIL rmid_async got %b addr=%h exp 0000 0", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, pmem_address); end
    i_pmem_read = 0;
    nxt(); rst = 0; #1;
    nxt(); #1;  // late pmem_resp still high across an IDLE edge
    vectors++; if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin miscompares++; $display("FAIL rmid_late got %b exp 0000", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}); end
    nxt(); pmem_resp = 0; d_pmem_read = 1; d_pmem_address = 32'h6000; #1;
    serve(2, '0, -1, w, wr, a, wd, ir, dr, st, bc);
    vectors++; if (w !== 1 || a !== 32'h6000 || wr !== 0 || dr !== 1) begin miscompares++; $display("FAIL rmid_next w=%0d addr=%h dr=%b exp 1 00006000 1", w, a, dr); end
    nxt(); pmem_resp = 0; clear_inputs(); #1;
  endtask

  // Random traffic. Each requester holds its request until it is served,
  // like a real cache. The model picks the grant from the pending set and
  // the side that won the previous grant.
  task automatic test_random();
    int w, side, exp_w, dop; logic wr, ir, dr, st, bc, last_d, ip, dp, dwr;
    logic [31:0] a, ia, da; logic [255:0] wd, dwd, rd;
    do_reset();
    last_d = 0; ip = 0; dp = 0; dwr = 0; ia = 0; da = 0; dwd = '0; exp_w = 1;
    for (int t = 0; t < 60; t++) begin
      if (!ip && $urandom_range(1)) begin ip = 1; ia = $urandom; end
      if (!dp && $urandom_range(1)) begin dp = 1; da = $urandom; dwd = {8{$urandom}}; dop = $urandom_range(2); end
      if (!ip && !dp) begin dp = 1; da = $urandom; dwd = {8{$urandom}}; dop = $urandom_range(2); end
      i_pmem_read = ip; i_pmem_address = ia;
      d_pmem_address = da; d_pmem_wdata = dwd;
      if (dp) begin d_pmem_read = (dop != 1); d_pmem_write = (dop != 0); end
      dwr = (dop != 0);
      side = (ip && dp) ? (last_d ? 0 : 1) : (dp ? 1 : 0);
      #1;
      rd = {8{$urandom}};
      serve($urandom_range(3), rd, -1, w, wr, a, wd, ir, dr, st, bc);
      vectors++;
      if (w !== exp_w || a !== (side ? da : ia) || wr !== (side ? dwr : 1'b0) ||
          wd !== ((side && dwr) ? dwd : 256'h0) || ir !== (side == 0) ||
          dr !== (side == 1) || !st || !bc) begin
        miscompares++;
        $display("FAIL rand_%0d side=%0d w=%0d/%0d addr=%h/%h wr=%b ir=%b dr=%b st=%b bc=%b",
                 t, side, w, exp_w, a, side ? da : ia, wr, ir, dr, st, bc);
      end
      last_d = (side == 1);
      nxt();
      if (side) begin dp = 0; d_pmem_read = 0; d_pmem_write = 0; end
      else begin ip = 0; i_pmem_read = 0; end
      pmem_resp = $urandom_range(1);  // must be ignored in COOLDOWN
      #1;
      vectors++;
      if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0) begin
        miscompares++; $display("FAIL rand_cool_%0d got %b exp 0000", t, {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
      end
      pmem_resp = 0;
      exp_w = 2;
    end
    nxt(); clear_inputs();
  endtask

  initial begin
    test_reset();
    test_lone_i();
    test_lone_d_write();
    test_simultaneous();
    test_anti_starvation();
    test_input_stability();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
